timer_counter: RTL and testbench

- Parametrised 8051 timer/counter channel; one instance per timer (TIMER_ID 0 or 1) on the SFR bus.
- Owns the TLx and THx registers, this timer's TMOD nibble, and its TRx/TFx bits in TCON.
- Implements modes 0–3, timer or counter source, GATE qualification and overflow flag with interrupt-acknowledge clear.
- Supersedes the standalone single-register SFR blocks for timer state.

---
 rtl/timer_counter_pkg.sv | 32 +++
 rtl/timer_counter_tick.sv | 48 ++++
 rtl/timer_counter.sv | 146 ++++++++++++++
 tb/tb_timer_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared SFR addresses, TCON bit positions and mode encodings for the 8051 timer channels.
// TIMER_MODE3_EN selects whether mode 3 is the split counter or an alias of mode 1.
package timer_counter_pkg;

    localparam logic [7:0] SFR_TCON = 8'h88;
    localparam logic [7:0] SFR_TMOD = 8'h89;
    localparam logic [7:0] SFR_TL0  = 8'h8A;
    localparam logic [7:0] SFR_TL1  = 8'h8B;
    localparam logic [7:0] SFR_TH0  = 8'h8C;
    localparam logic [7:0] SFR_TH1  = 8'h8D;

    localparam logic [2:0] TCON_TR0 = 3'd4;
    localparam logic [2:0] TCON_TF0 = 3'd5;
    localparam logic [2:0] TCON_TR1 = 3'd6;
    localparam logic [2:0] TCON_TF1 = 3'd7;

    typedef enum logic [1:0] {
        MODE_13BIT       = 2'b00,
        MODE_16BIT       = 2'b01,
        MODE_8BIT_RELOAD = 2'b10,
        MODE_SPLIT       = 2'b11
    } mode_e;

    function automatic mode_e effective_mode(input logic [1:0] m);
`ifdef TIMER_MODE3_EN
        return mode_e'(m);
`else
        return (mode_e'(m) == MODE_SPLIT) ? MODE_16BIT : mode_e'(m);
`endif
    endfunction

endpackage

// File: rtl/timer_counter_tick.sv
// Tick source for one timer channel: free-running machine-cycle prescaler plus
// synchronised T-pin falling-edge detector and INT-pin synchroniser.
module timer_tick_gen #(
    parameter int unsigned PRESCALE    = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic count_sel,
    input  logic t_pin,
    input  logic int_pin,
    output logic mach_tick,
    output logic tick,
    output logic int_sync
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]          pre;
    logic [SYNC_STAGES-1:0] t_sync;
    logic [SYNC_STAGES-1:0] i_sync;
    logic                   t_prev;
    logic                   t_now;

    assign mach_tick = (pre == PW'(PRESCALE - 1));
    assign t_now     = t_sync[SYNC_STAGES-1];
    assign int_sync  = i_sync[SYNC_STAGES-1];

    // The pin is only looked at once per machine cycle, so a falling edge is
    // a high sample on one machine tick followed by a low sample on the next.
    assign tick = count_sel ? (mach_tick & t_prev & ~t_now) : mach_tick;

    always_ff @(posedge clock) begin
        if (reset) begin
            pre    <= '0;
            t_sync <= '0;
            i_sync <= '0;
            t_prev <= 1'b0;
        end else begin
            pre    <= mach_tick ? '0 : pre + 1'b1;
            t_sync <= (t_sync << 1) | SYNC_STAGES'(t_pin);
            i_sync <= (i_sync << 1) | SYNC_STAGES'(int_pin);
            if (mach_tick)
                t_prev <= t_now;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// 8051 timer/counter channel (TLx/THx, TMOD nibble, TRx/TFx) on the SFR bus.
// Define TIMER_MODE3_EN to build the mode 3 split counter; otherwise mode 3 runs as mode 1.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned TIMER_ID    = 0,
    parameter int unsigned PRESCALE    = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] addr,
    input  logic       wr_en,
    input  logic       wr_bit_en,
    input  logic       bit_in,
    input  logic       t_pin,
    input  logic       int_pin,
    input  logic       int_ack,
    input  logic       tr_other,
    output logic [7:0] tl_data,
    output logic [7:0] th_data,
    output logic [3:0] tmod_nib,
    output logic       tr,
    output logic       tf,
    output logic       tf_other_set
);

    localparam logic [7:0] TL_ADDR = (TIMER_ID == 0) ? SFR_TL0 : SFR_TL1;
    localparam logic [7:0] TH_ADDR = (TIMER_ID == 0) ? SFR_TH0 : SFR_TH1;
    localparam logic [2:0] TR_BIT  = (TIMER_ID == 0) ? TCON_TR0 : TCON_TR1;
    localparam logic [2:0] TF_BIT  = (TIMER_ID == 0) ? TCON_TF0 : TCON_TF1;

    logic        mach_tick, tick, int_sync;
    logic        byte_wr, bit_wr;
    logic        wr_tl, wr_th, wr_tmod, wr_tcon, wr_tr_bit, wr_tf_bit;
    logic        run, cnt_en;
    mode_e       mode;
    logic [7:0]  tl_nxt, th_nxt;
    logic        ovf, th_ovf;
    logic [12:0] sum13;
    logic [15:0] sum16;

    timer_tick_gen #(
        .PRESCALE    (PRESCALE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick (
        .clock     (clock),
        .reset     (reset),
        .count_sel (tmod_nib[2]),
        .t_pin     (t_pin),
        .int_pin   (int_pin),
        .mach_tick (mach_tick),
        .tick      (tick),
        .int_sync  (int_sync)
    );

    assign byte_wr   = wr_en & ~wr_bit_en;
    assign bit_wr    = wr_en & wr_bit_en;
    assign wr_tl     = byte_wr & (addr == TL_ADDR);
    assign wr_th     = byte_wr & (addr == TH_ADDR);
    assign wr_tmod   = byte_wr & (addr == SFR_TMOD);
    assign wr_tcon   = byte_wr & (addr == SFR_TCON);
    assign wr_tr_bit = bit_wr & (addr == SFR_TCON + {5'd0, TR_BIT});
    assign wr_tf_bit = bit_wr & (addr == SFR_TCON + {5'd0, TF_BIT});

    assign mode   = effective_mode(tmod_nib[1:0]);
    assign run    = tr & (~tmod_nib[3] | int_sync);
    // A software write to either counter byte discards a coincident tick.
    assign cnt_en = tick & run & ~wr_tl & ~wr_th;

    always_comb begin
        tl_nxt = tl_data;
        th_nxt = th_data;
        ovf    = 1'b0;
        th_ovf = 1'b0;
        sum13  = {th_data, tl_data[4:0]} + 13'd1;
        sum16  = {th_data, tl_data} + 16'd1;
        if (cnt_en) begin
            case (mode)
                MODE_13BIT: begin
                    tl_nxt = {tl_data[7:5], sum13[4:0]};
                    th_nxt = sum13[12:5];
                    ovf    = &{th_data, tl_data[4:0]};
                end
                MODE_16BIT: begin
                    {th_nxt, tl_nxt} = sum16;
                    ovf              = &{th_data, tl_data};
                end
                MODE_8BIT_RELOAD: begin
                    tl_nxt = (&tl_data) ? th_data : tl_data + 8'd1;
                    ovf    = &tl_data;
                end
                MODE_SPLIT: begin
                    if (TIMER_ID == 0) begin
                        tl_nxt = tl_data + 8'd1;
                        ovf    = &tl_data;
                    end
                end
                default: ;
            endcase
        end
`ifdef TIMER_MODE3_EN
        // Timer0 mode 3: TH0 is an independent machine-cycle counter run by TR1.
        if (TIMER_ID == 0 && mode == MODE_SPLIT && mach_tick && tr_other && !wr_th) begin
            th_nxt = th_data + 8'd1;
            th_ovf = &th_data;
        end
`endif
    end

`ifndef TIMER_MODE3_EN
    logic unused_split;
    assign unused_split = ^{tr_other, mach_tick};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            tl_data      <= '0;
            th_data      <= '0;
            tmod_nib     <= '0;
            tr           <= 1'b0;
            tf           <= 1'b0;
            tf_other_set <= 1'b0;
        end else begin
            tl_data <= wr_tl ? data_in : tl_nxt;
            th_data <= wr_th ? data_in : th_nxt;
            if (wr_tmod)
                tmod_nib <= (TIMER_ID == 0) ? data_in[3:0] : data_in[7:4];
            if (wr_tcon)
                tr <= data_in[TR_BIT];
            else if (wr_tr_bit)
                tr <= bit_in;
            if (ovf)
                tf <= 1'b1;
            else if (wr_tcon)
                tf <= data_in[TF_BIT];
            else if (wr_tf_bit)
                tf <= bit_in;
            else if (int_ack)
                tf <= 1'b0;
            tf_other_set <= th_ovf;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter (TIMER_ID=0, PRESCALE=12); TIMER_MODE3_EN selects mode 3 expectations.
module tb_timer_counter;

    localparam int unsigned PRE = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] addr = '0;
    logic       wr_en = 1'b0, wr_bit_en = 1'b0, bit_in = 1'b0;
    logic       t_pin = 1'b0, int_pin = 1'b0, int_ack = 1'b0, tr_other = 1'b0;
    logic [7:0] tl_data, th_data;
    logic [3:0] tmod_nib;
    logic       tr, tf, tf_other_set;

    timer_counter #(
        .TIMER_ID    (0),
        .PRESCALE    (PRE),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .addr         (addr),
        .wr_en        (wr_en),
        .wr_bit_en    (wr_bit_en),
        .bit_in       (bit_in),
        .t_pin        (t_pin),
        .int_pin      (int_pin),
        .int_ack      (int_ack),
        .tr_other     (tr_other),
        .tl_data      (tl_data),
        .th_data      (th_data),
        .tmod_nib     (tmod_nib),
        .tr           (tr),
        .tf           (tf),
        .tf_other_set (tf_other_set)
    );

    always #5 clock = ~clock;

    typedef enum {SEL_TL, SEL_TH, SEL_TMOD, SEL_TR, SEL_TF, SEL_OTHER} sel_e;
    typedef struct {
        string      tag;
        sel_e       sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] observe(input sel_e s);
        case (s)
            SEL_TL:    return tl_data;
            SEL_TH:    return th_data;
            SEL_TMOD:  return {4'd0, tmod_nib};
            SEL_TR:    return {7'd0, tr};
            SEL_TF:    return {7'd0, tf};
            default:   return {7'd0, tf_other_set};
        endcase
    endfunction

    task automatic expect_out(input string tag, input sel_e s, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, {8'd0, observe(e.sel)}, {8'd0, e.exp});
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; wr_bit_en = 1'b0; int_ack = 1'b0;
        t_pin = 1'b0; int_pin = 1'b0; tr_other = 1'b0;
        step();
        cyc   = 0;
        reset = 1'b0;
    endtask

    task automatic byte_wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; wr_en = 1'b1; wr_bit_en = 1'b0;
        step();
        wr_en = 1'b0;
    endtask

    task automatic bit_wr(input logic [7:0] a, input logic b);
        addr = a; bit_in = b; wr_en = 1'b1; wr_bit_en = 1'b1;
        step();
        wr_en = 1'b0; wr_bit_en = 1'b0;
    endtask

    // Leave the bench so that the next edge is a machine-cycle tick edge.
    task automatic to_tick();
        while (((cyc + 1) % PRE) != 0) step();
    endtask

    task automatic pulse_t(input int n);
        for (int i = 0; i < n; i++) begin
            t_pin = 1'b1;
            repeat (30) step();
            t_pin = 1'b0;
            repeat (30) step();
        end
    endtask

    initial begin
        int n;

        // Mode 1 timer: FFFE needs two ticks to overflow
        do_reset();
        byte_wr(8'h89, 8'h01);
        byte_wr(8'h8A, 8'hFE);
        byte_wr(8'h8C, 8'hFF);
        to_tick();
        bit_wr(8'h8C, 1'b1);
        n = 0;
        while (tf !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq("m1_latency", 16'(n), 16'd24);
        expect_out("m1_tl", SEL_TL, 8'h00);
        expect_out("m1_th", SEL_TH, 8'h00);
        expect_out("m1_tf", SEL_TF, 8'h01);
        drain();

        // Reset from a busy state
        do_reset();
        expect_out("rst_tl", SEL_TL, 8'h00);
        expect_out("rst_th", SEL_TH, 8'h00);
        expect_out("rst_tmod", SEL_TMOD, 8'h00);
        expect_out("rst_tr", SEL_TR, 8'h00);
        expect_out("rst_tf", SEL_TF, 8'h00);
        expect_out("rst_other", SEL_OTHER, 8'h00);
        drain();

        // Mode 2 auto-reload, then interrupt acknowledge
        byte_wr(8'h89, 8'h02);
        byte_wr(8'h8C, 8'hF0);
        byte_wr(8'h8A, 8'hFF);
        to_tick();
        bit_wr(8'h8C, 1'b1);
        expect_out("m2_tr", SEL_TR, 8'h01);
        expect_out("m2_tmod", SEL_TMOD, 8'h02);
        drain();
        to_tick();
        step();
        expect_out("m2_tl", SEL_TL, 8'hF0);
        expect_out("m2_th", SEL_TH, 8'hF0);
        expect_out("m2_tf", SEL_TF, 8'h01);
        drain();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        expect_out("m2_ack", SEL_TF, 8'h00);
        drain();

        // Mode 0 13-bit wrap preserves TL[7:5]
        do_reset();
        byte_wr(8'h8A, 8'hBF);
        byte_wr(8'h8C, 8'hFF);
        to_tick();
        bit_wr(8'h8C, 1'b1);
        to_tick();
        step();
        expect_out("m0_tl", SEL_TL, 8'hA0);
        expect_out("m0_th", SEL_TH, 8'h00);
        expect_out("m0_tf", SEL_TF, 8'h01);
        drain();

        // GATE + counter source
        do_reset();
        byte_wr(8'h89, 8'h0D);
        bit_wr(8'h8C, 1'b1);
        pulse_t(5);
        expect_out("gate_off_tl", SEL_TL, 8'h00);
        drain();
        int_pin = 1'b1;
        repeat (30) step();
        pulse_t(5);
        expect_out("gate_on_tl", SEL_TL, 8'h05);
        expect_out("gate_on_th", SEL_TH, 8'h00);
        expect_out("gate_on_tf", SEL_TF, 8'h00);
        drain();

        // Write vs tick, and overflow vs int_ack on the same edge
        do_reset();
        byte_wr(8'h89, 8'h01);
        byte_wr(8'h8A, 8'h10);
        to_tick();
        bit_wr(8'h8C, 1'b1);
        to_tick();
        byte_wr(8'h8A, 8'h33);
        expect_out("wr_wins_tl", SEL_TL, 8'h33);
        drain();
        byte_wr(8'h8A, 8'hFF);
        byte_wr(8'h8C, 8'hFF);
        to_tick();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        expect_out("set_wins_tf", SEL_TF, 8'h01);
        expect_out("set_wins_tl", SEL_TL, 8'h00);
        expect_out("set_wins_th", SEL_TH, 8'h00);
        drain();

        // Mode 3 (split when enabled, mode 1 alias otherwise)
        do_reset();
        byte_wr(8'h89, 8'h03);
        byte_wr(8'h8C, 8'hFF);
        bit_wr(8'h8C, 1'b1);
        tr_other = 1'b1;
        to_tick();
        step();
`ifdef TIMER_MODE3_EN
        expect_out("m3_th", SEL_TH, 8'h00);
        expect_out("m3_tl", SEL_TL, 8'h01);
        expect_out("m3_other", SEL_OTHER, 8'h01);
`else
        expect_out("m3_th", SEL_TH, 8'hFF);
        expect_out("m3_tl", SEL_TL, 8'h01);
        expect_out("m3_other", SEL_OTHER, 8'h00);
`endif
        expect_out("m3_tf", SEL_TF, 8'h00);
        drain();
        step();
        expect_out("m3_other_pulse", SEL_OTHER, 8'h00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
